// File: rtl/wb_rr_arbiter_2m.sv
// Two-master, one-slave Wishbone classic arbiter. Round-robin between the VME core
// and the housekeeping master, grant locked for the whole CYC, with a bus watchdog.
module wb_rr_arbiter_2m #(
    parameter int AW      = 32,
    parameter int DW      = 32,
    parameter int TIMEOUT = 255
) (
    input  logic                clk_sys_i,
    input  logic                rst_i,
    input  logic [1:0]          m_cyc_i,
    input  logic [1:0]          m_stb_i,
    input  logic [1:0]          m_we_i,
    input  logic [2*AW-1:0]     m_adr_i,
    input  logic [2*DW/8-1:0]   m_sel_i,
    input  logic [2*DW-1:0]     m_dat_i,
    output logic [DW-1:0]       m_dat_o,
    output logic [1:0]          m_ack_o,
    output logic [1:0]          m_err_o,
    output logic                s_cyc_o,
    output logic                s_stb_o,
    output logic                s_we_o,
    output logic [AW-1:0]       s_adr_o,
    output logic [DW/8-1:0]     s_sel_o,
    output logic [DW-1:0]       s_dat_o,
    input  logic [DW-1:0]       s_dat_i,
    input  logic                s_ack_i,
    input  logic                s_err_i,
    output logic [1:0]          grant_o,
    output logic                timeout_o
);

    localparam int SW = DW / 8;
    localparam int TW = $clog2(TIMEOUT + 1);
    localparam logic [TW-1:0] TCNT_LAST = TW'(TIMEOUT - 1);

    localparam logic [1:0] GNT_IDLE = 2'b00;
    localparam logic [1:0] GNT_M0   = 2'b01;
    localparam logic [1:0] GNT_M1   = 2'b10;

    logic [1:0]    grant_q, grant_d;
    logic          last_q, last_d;
    logic [TW-1:0] tcnt_q, tcnt_d;
    logic          timeout_q, timeout_d;
    logic          timeout;

    logic [AW-1:0] adr_m [2];
    logic [SW-1:0] sel_m [2];
    logic [DW-1:0] dat_m [2];

    // Each master's bus fields are zeroed unless it holds the grant, then OR-merged.
    generate
        for (genvar gi = 0; gi < 2; gi++) begin : g_mux
            assign adr_m[gi] = grant_q[gi] ? m_adr_i[gi*AW +: AW] : '0;
            assign sel_m[gi] = grant_q[gi] ? m_sel_i[gi*SW +: SW] : '0;
            assign dat_m[gi] = grant_q[gi] ? m_dat_i[gi*DW +: DW] : '0;
        end
    endgenerate

    assign s_adr_o   = adr_m[0] | adr_m[1];
    assign s_sel_o   = sel_m[0] | sel_m[1];
    assign s_dat_o   = dat_m[0] | dat_m[1];
    assign s_cyc_o   = |(grant_q & m_cyc_i);
    assign s_stb_o   = |(grant_q & m_cyc_i & m_stb_i);
    assign s_we_o    = |(grant_q & m_we_i);
    assign m_dat_o   = s_dat_i;
    assign grant_o   = grant_q;
    assign timeout_o = timeout_q;

    // An ACK or ERR on the expiry cycle suppresses the timeout.
    assign timeout = s_stb_o & ~s_ack_i & ~s_err_i & (tcnt_q == TCNT_LAST);
    assign m_ack_o = {2{s_ack_i}} & grant_q;
    assign m_err_o = {2{s_err_i | timeout}} & grant_q;

    always_comb begin
        grant_d = grant_q;
        last_d  = last_q;
        case (grant_q)
            GNT_IDLE: begin
                if (m_cyc_i == 2'b11)
                    grant_d = last_q ? GNT_M0 : GNT_M1;
                else
                    grant_d = m_cyc_i;
            end
            GNT_M0: begin
                if (!m_cyc_i[0]) begin
                    grant_d = GNT_IDLE;
                    last_d  = 1'b0;
                end
            end
            GNT_M1: begin
                if (!m_cyc_i[1]) begin
                    grant_d = GNT_IDLE;
                    last_d  = 1'b1;
                end
            end
            default: grant_d = GNT_IDLE;
        endcase
    end

    always_comb begin
        tcnt_d    = tcnt_q + 1'b1;
        timeout_d = timeout;
        if ((grant_d != grant_q) || !s_stb_o || s_ack_i || s_err_i || timeout)
            tcnt_d = '0;
    end

    always_ff @(posedge clk_sys_i or posedge rst_i) begin
        if (rst_i) begin
            grant_q   <= GNT_IDLE;
            last_q    <= 1'b1;
            tcnt_q    <= '0;
            timeout_q <= 1'b0;
        end else begin
            grant_q   <= grant_d;
            last_q    <= last_d;
            tcnt_q    <= tcnt_d;
            timeout_q <= timeout_d;
        end
    end

endmodule
